boot_loader: RTL and testbench
==============================

# boot_loader

Byte-stream program loader sitting between a host/debug link and the monocycle MIPS core's instruction and data memories. It parses framed load commands and writes payload bytes into the byte-addressed instruction memory (IM) or data memory (DM). It holds the CPU in reset until a RUN command arrives, so images load through RTL rather than hierarchical bench pokes. It supports configurable memory depths and an optional frame checksum.

## Interface
- `ADDR_W`, 16: memory byte-address width; legal range 8–16.
- `IM_DEPTH`, 1024: IM size in bytes.
- `DM_DEPTH`, 1024: DM size in bytes.
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  byte present.
- `in_ready`  out  1  loader accepts the byte; transfer occurs when `in_valid && in_ready`.
- `im_we`  out  1  IM byte write strobe.
- `dm_we`  out  1  DM byte write strobe.
- `mem_addr`  out  ADDR_W  byte address shared by both memories.
- `mem_wdata`  out  8  byte to write.
- `cpu_reset`  out  1  active-high hold to the CPU's reset input.
- `busy`  out  1  a frame is in progress.
- `error`  out  1  sticky fault flag.

## Operation
- Frame format: CMD, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, then LEN payload bytes, then CSUM (only with checksum enabled). All fields are big-endian.
- CMD codes:
  - 0x01: load IM.
  - 0x02: load DM.
  - 0x03: RUN. RUN is a single byte with no further fields.
  - Any other code: error.
- States and transitions:
  - IDLE → A_HI → A_LO → L_HI → L_LO → DATA → (CSUM) → IDLE. Each state advances on one accepted byte.
  - IDLE on 0x03 → RUN.
  - IDLE on an illegal CMD → ERR.
- Range check at L_LO: computed in 17 bits as ADDR + LEN, compared against the target depth.
  - If ADDR + LEN > depth, or ADDR ≥ 2^ADDR_W: go to ERR; no write is issued.
- LEN = 0: L_LO goes straight to CSUM (checksum enabled) or IDLE.
- DATA: each accepted byte produces one write to the target at ADDR + n, where n counts 0..LEN-1. Leave DATA after byte LEN-1.
- Byte order inside a 32-bit word is as the memories store it: byte 0 is the MSB.
- RUN state: `cpu_reset`=0, `in_ready`=0. The loader stays in RUN until `reset`.
- ERR state: `error`=1, `in_ready`=0, `cpu_reset` stays 1. The loader stays in ERR until `reset`.
- `busy`=1 in every state except IDLE, RUN and ERR.
- The `in_valid`=0 gap is unbounded in any state; the FSM holds its state with no timeout.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `im_we`=`dm_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_reset`=1, `busy`=0, `error`=0.
- `in_ready` is a registered function of state. It is 1 in IDLE, A_*, L_*, DATA and CSUM.
- Sustained throughput is one byte per cycle, including at every state boundary.
- Write latency: the byte accepted at edge k drives `*_we`, `mem_addr` and `mem_wdata` registered from edge k. The strobe is one cycle wide per byte.
- RUN accepted at edge k: `cpu_reset` falls from edge k.
- Asserting `reset` mid-frame:
  - Immediately clears all outputs and forces `cpu_reset`=1.
  - Memory contents already written are kept, because the memories are not reset.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - Each load frame carries a CSUM byte.
  - The 8-bit sum of all frame bytes, CSUM included, must equal 0x00.
  - Mismatch → ERR, which blocks RUN. Bytes already written are not rolled back.
  - The RUN command carries no checksum.
- `BOOT_CHECKSUM_EN` undefined: there is no CSUM state, and the frame ends after the last payload byte.

## Structure
- Shared package `boot_pkg` holds:
  - CMD codes: `CMD_LOAD_IM`, `CMD_LOAD_DM`, `CMD_RUN`.
  - The FSM state enum.
  - The frame header length constant.
- One sub-module, `boot_checksum`: 8-bit accumulator with clear/add/zero-check. It is instantiated only under `BOOT_CHECKSUM_EN`.
- The CPU top level instantiates `boot_loader` and ORs nothing into the CPU reset: `cpu_reset` is the CPU's sole reset source.

## Test plan
- IM load, checksum off. Stream 01 00 00 00 04 3C 01 10 01 back-to-back.
  - Required: `im_we` on 4 consecutive cycles, addresses 0–3, data 3C/01/10/01.
  - `dm_we` stays 0; `busy` returns to 0.
- DM load then RUN. Stream 02 00 1C 00 04 00 00 00 08, then 03.
  - Required: DM bytes 28–31 written.
  - `cpu_reset` falls on the edge after 03 is accepted; `in_ready`=0 afterwards.
- Range fault. Stream 01 03 FE 00 04 with IM_DEPTH=1024.
  - Required: ERR after LEN_LO, `error`=1, no `im_we` pulse.
  - A following 03 is not accepted and `cpu_reset` stays 1.
- Illegal CMD and LEN=0.
  - Stream 05: → ERR.
  - After reset, stream 01 00 10 00 00: → IDLE with no write.
- Checksum on. Frame 02 00 00 00 01 AA with CSUM=0x53 (total 0x00), then 03 → `cpu_reset` 0.
  - The same frame with CSUM=0x54 → `error`=1 and RUN is blocked.
- Stalls and reset mid-frame.
  - Random `in_valid` gaps during an IM load: writes are identical to the back-to-back case.
  - Drop `reset` after payload byte 2: all outputs return to their reset values within the same cycle.

Source files
------------

// File: rtl/boot_pkg.sv
// boot_pkg: shared definitions for the byte-stream program loader.
// Holds the frame command codes, the loader FSM state encoding and the
// fixed frame header length (CMD + 2 address bytes + 2 length bytes).
package boot_pkg;

    localparam logic [7:0] CMD_LOAD_IM = 8'h01;
    localparam logic [7:0] CMD_LOAD_DM = 8'h02;
    localparam logic [7:0] CMD_RUN     = 8'h03;

    localparam int HDR_LEN = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_A_HI,
        ST_A_LO,
        ST_L_HI,
        ST_L_LO,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERR
    } boot_state_e;

    // The two terminal states refuse further bytes; every other state accepts.
    function automatic logic state_accepts(boot_state_e s);
        return !(s == ST_RUN || s == ST_ERR);
    endfunction

endpackage

// File: rtl/boot_checksum.sv
// boot_checksum: 8-bit running frame sum with clear, add and zero check.
// zero_o reports whether the sum *including* the byte presented this cycle
// is zero, so the closing CSUM byte can be judged on the cycle it arrives.
module boot_checksum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       add_i,
    input  logic [7:0] data_i,
    output logic       zero_o
);

    logic [7:0] sum_q, sum_d;

    // Next sum: optionally restart from zero, then fold in the current byte.
    always_comb begin
        sum_d  = (clr_i ? 8'h00 : sum_q) + (add_i ? data_i : 8'h00);
        zero_o = (sum_d == 8'h00);
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= 8'h00;
        else        sum_q <= sum_d;
    end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: parses CMD/ADDR/LEN framed load commands from a byte stream
// and writes the payload into the CPU instruction or data memory, holding
// the CPU in reset until a RUN command arrives. Define BOOT_CHECKSUM_EN to
// require a trailing CSUM byte on every load frame (frame sum must be 0).
module boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int IM_DEPTH = 1024,
    parameter int DM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic              dm_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              error
);

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_e FRAME_END = ST_CSUM;
`else
    localparam boot_state_e FRAME_END = ST_IDLE;
`endif

    boot_state_e       state_q, state_d;
    logic              is_dm_q, is_dm_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       rem_q, rem_d;

    logic              in_ready_q, in_ready_d;
    logic              im_we_q, im_we_d;
    logic              dm_we_q, dm_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;

    logic              accept;
    logic              wr;
    logic [15:0]       len_w;
    logic [16:0]       end_w;
    logic [31:0]       depth_w;
    logic              range_bad;
    logic              csum_ok;

    assign accept    = in_valid && in_ready_q;
    assign wr        = accept && (state_q == ST_DATA);
    assign len_w     = {len_hi_q, in_data};
    assign end_w     = {1'b0, addr_q} + {1'b0, len_w};
    assign depth_w   = is_dm_q ? 32'(DM_DEPTH) : 32'(IM_DEPTH);
    assign range_bad = (32'(end_w) > depth_w) || ((32'(addr_q) >> ADDR_W) != 32'd0);

`ifdef BOOT_CHECKSUM_EN
    boot_checksum u_csum (
        .clk    (clk),
        .rst_n  (reset),
        .clr_i  (accept && (state_q == ST_IDLE)),
        .add_i  (accept),
        .data_i (in_data),
        .zero_o (csum_ok)
    );
`else
    assign csum_ok = 1'b1;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: each accepted byte advances the frame parser.
    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_data == CMD_LOAD_IM || in_data == CMD_LOAD_DM) state_d = ST_A_HI;
                    else if (in_data == CMD_RUN)                          state_d = ST_RUN;
                    else                                                  state_d = ST_ERR;
                end
                ST_A_HI: state_d = ST_A_LO;
                ST_A_LO: state_d = ST_L_HI;
                ST_L_HI: state_d = ST_L_LO;
                ST_L_LO: begin
                    if (range_bad)           state_d = ST_ERR;
                    else if (len_w == 16'd0) state_d = FRAME_END;
                    else                     state_d = ST_DATA;
                end
                ST_DATA: if (rem_q == 16'd1) state_d = FRAME_END;
                ST_CSUM: state_d = csum_ok ? ST_IDLE : ST_ERR;
                default: state_d = state_q;
            endcase
        end
    end

    // Frame datapath: capture target, address and length; walk the payload.
    always_comb begin
        is_dm_d  = is_dm_q;
        addr_d   = addr_q;
        len_hi_d = len_hi_q;
        rem_d    = rem_q;
        if (accept) begin
            case (state_q)
                ST_IDLE: is_dm_d       = (in_data == CMD_LOAD_DM);
                ST_A_HI: addr_d[15:8]  = in_data;
                ST_A_LO: addr_d[7:0]   = in_data;
                ST_L_HI: len_hi_d      = in_data;
                ST_L_LO: rem_d         = len_w;
                ST_DATA: begin
                    addr_d = addr_q + 16'd1;
                    rem_d  = rem_q - 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Output decode: all outputs are registered from the next state / write.
    always_comb begin
        im_we_d     = wr && !is_dm_q;
        dm_we_d     = wr && is_dm_q;
        mem_addr_d  = wr ? addr_q[ADDR_W-1:0] : mem_addr_q;
        mem_wdata_d = wr ? in_data : mem_wdata_q;
        in_ready_d  = state_accepts(state_d);
        cpu_reset_d = (state_d != ST_RUN);
        busy_d      = !(state_d == ST_IDLE || state_d == ST_RUN || state_d == ST_ERR);
        error_d     = (state_d == ST_ERR);
    end

    // Datapath and output registers; reset forces the CPU back into reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_dm_q     <= 1'b0;
            addr_q      <= '0;
            len_hi_q    <= '0;
            rem_q       <= '0;
            in_ready_q  <= 1'b1;
            im_we_q     <= 1'b0;
            dm_we_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            is_dm_q     <= is_dm_d;
            addr_q      <= addr_d;
            len_hi_q    <= len_hi_d;
            rem_q       <= rem_d;
            in_ready_q  <= in_ready_d;
            im_we_q     <= im_we_d;
            dm_we_q     <= dm_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign im_we     = im_we_q;
    assign dm_we     = dm_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign error     = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed bench for boot_loader. Load frames carry a CSUM
// byte only when BOOT_CHECKSUM_EN is defined for the build.
`timescale 1ns/1ps
module tb_boot_loader;
    import boot_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        im_we;
    logic        dm_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        error;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  acc;

    boot_loader #(.ADDR_W(16), .IM_DEPTH(1024), .DM_DEPTH(1024)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .im_we     (im_we),
        .dm_we     (dm_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte and let one edge pass; sample 1 ns after the edge.
    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        acc      = acc + b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] addr, input logic [15:0] len);
        logic [7:0] h [HDR_LEN];
        h[0] = cmd;
        h[1] = addr[15:8];
        h[2] = addr[7:0];
        h[3] = len[15:8];
        h[4] = len[7:0];
        acc  = 8'h00;
        for (int i = 0; i < HDR_LEN; i++) send(h[i]);
    endtask

    task automatic send_csum();
`ifdef BOOT_CHECKSUM_EN
        send(~acc + 8'd1);
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_im_we"},     32'(im_we),     32'd0);
        check({tag, "_dm_we"},     32'(dm_we),     32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_error"},     32'(error),     32'd0);
    endtask

    task automatic do_reset(input string tag);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] pl_im [4];
        logic [7:0] pl_dm [4];
        int         gap;
        pl_im = '{8'h3C, 8'h01, 8'h10, 8'h01};
        pl_dm = '{8'h00, 8'h00, 8'h00, 8'h08};
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        acc      = 8'h00;
        #12;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;

        // IM load, back-to-back.
        send_hdr(CMD_LOAD_IM, 16'h0000, 16'h0004);
        check("t1_busy_hdr", 32'(busy), 32'd1);
        check("t1_we_hdr",   32'(im_we), 32'd0);
        for (int i = 0; i < 4; i++) begin
            send(pl_im[i]);
            check($sformatf("t1_im_we%0d", i),  32'(im_we),     32'd1);
            check($sformatf("t1_dm_we%0d", i),  32'(dm_we),     32'd0);
            check($sformatf("t1_addr%0d", i),   32'(mem_addr),  32'(i));
            check($sformatf("t1_wdata%0d", i),  32'(mem_wdata), 32'(pl_im[i]));
        end
        send_csum();
        idle(1);
        check("t1_we_end",   32'(im_we), 32'd0);
        check("t1_busy_end", 32'(busy),  32'd0);
        check("t1_ready",    32'(in_ready), 32'd1);

        // DM load then RUN.
        send_hdr(CMD_LOAD_DM, 16'h001C, 16'h0004);
        for (int i = 0; i < 4; i++) begin
            send(pl_dm[i]);
            check($sformatf("t2_dm_we%0d", i), 32'(dm_we),     32'd1);
            check($sformatf("t2_im_we%0d", i), 32'(im_we),     32'd0);
            check($sformatf("t2_addr%0d", i),  32'(mem_addr),  32'(28 + i));
            check($sformatf("t2_wdata%0d", i), 32'(mem_wdata), 32'(pl_dm[i]));
        end
        send_csum();
        check("t2_cpu_reset_pre", 32'(cpu_reset), 32'd1);
        send(CMD_RUN);
        check("t2_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t2_ready",     32'(in_ready),  32'd0);
        check("t2_busy",      32'(busy),      32'd0);
        idle(2);
        check("t2_cpu_reset_hold", 32'(cpu_reset), 32'd0);
        do_reset("t2_rst");

        // Range fault: 0x3FE + 4 > 1024.
        send_hdr(CMD_LOAD_IM, 16'h03FE, 16'h0004);
        check("t3_error", 32'(error),    32'd1);
        check("t3_ready", 32'(in_ready), 32'd0);
        check("t3_im_we", 32'(im_we),    32'd0);
        check("t3_busy",  32'(busy),     32'd0);
        send(CMD_RUN);
        check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t3_im_we2",    32'(im_we),     32'd0);
        check("t3_error2",    32'(error),     32'd1);
        do_reset("t3_rst");

        // Exact fit at the top of DM: 0x3FF + 1 == 1024 is legal.
        send_hdr(CMD_LOAD_DM, 16'h03FF, 16'h0001);
        check("t3b_error_hdr", 32'(error), 32'd0);
        send(8'h55);
        check("t3b_dm_we", 32'(dm_we),     32'd1);
        check("t3b_addr",  32'(mem_addr),  32'h3FF);
        check("t3b_wdata", 32'(mem_wdata), 32'h55);
        send_csum();
        idle(1);
        check("t3b_error", 32'(error), 32'd0);
        check("t3b_busy",  32'(busy),  32'd0);

        // Illegal command.
        send(8'h05);
        check("t4_error", 32'(error),    32'd1);
        check("t4_ready", 32'(in_ready), 32'd0);
        do_reset("t4_rst");

        // LEN = 0: no write, back to idle.
        send_hdr(CMD_LOAD_IM, 16'h0010, 16'h0000);
        check("t4b_im_we", 32'(im_we), 32'd0);
        check("t4b_error", 32'(error), 32'd0);
`ifdef BOOT_CHECKSUM_EN
        check("t4b_busy_csum", 32'(busy), 32'd1);
        send_csum();
`endif
        idle(1);
        check("t4b_busy",  32'(busy),     32'd0);
        check("t4b_we",    32'(im_we),    32'd0);
        check("t4b_ready", 32'(in_ready), 32'd1);

`ifdef BOOT_CHECKSUM_EN
        // Checksum: 02 00 00 00 01 AA + 53 sums to 0x00.
        send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h01); send(8'hAA);
        check("t5_dm_we", 32'(dm_we), 32'd1);
        send(8'h53);
        check("t5_error", 32'(error), 32'd0);
        check("t5_busy",  32'(busy),  32'd0);
        send(CMD_RUN);
        check("t5_cpu_reset", 32'(cpu_reset), 32'd0);
        do_reset("t5_rst");
        send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h01); send(8'hAA);
        send(8'h54);
        check("t5b_error", 32'(error), 32'd1);
        send(CMD_RUN);
        check("t5b_cpu_reset", 32'(cpu_reset), 32'd1);
        do_reset("t5b_rst");
`endif

        // IM load with random in_valid gaps.
        acc = 8'h00;
        send(CMD_LOAD_IM); idle($urandom_range(0, 2));
        send(8'h00);       idle($urandom_range(0, 2));
        send(8'h00);       idle($urandom_range(0, 2));
        send(8'h00);       idle($urandom_range(0, 2));
        send(8'h04);       idle($urandom_range(0, 2));
        for (int i = 0; i < 4; i++) begin
            send(pl_im[i]);
            check($sformatf("t6_im_we%0d", i), 32'(im_we),     32'd1);
            check($sformatf("t6_addr%0d", i),  32'(mem_addr),  32'(i));
            check($sformatf("t6_wdata%0d", i), 32'(mem_wdata), 32'(pl_im[i]));
            gap = $urandom_range(0, 3);
            idle(gap);
            if (gap > 0) check($sformatf("t6_gap_we%0d", i), 32'(im_we), 32'd0);
        end
        send_csum();
        idle(1);
        check("t6_busy", 32'(busy),  32'd0);
        check("t6_err",  32'(error), 32'd0);

        // Reset mid-frame after payload byte 2.
        send_hdr(CMD_LOAD_IM, 16'h0020, 16'h0008);
        send(8'hA0); send(8'hA1); send(8'hA2);
        check("t7_im_we", 32'(im_we),    32'd1);
        check("t7_addr",  32'(mem_addr), 32'h22);
        do_reset("t7_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
